alu_exec: RTL

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_exec.sv
// alu_exec: handshaked ALU execution unit.
//
// A request (alucontrol, a, b) is accepted when in_valid and in_ready are both
// high. Single-cycle operations (add, sub, and, or, slt, illegal codes) present
// their result on the cycle after accept. The result, zero and illegal outputs
// then hold until the consumer raises out_ready, which returns the unit to IDLE.
// in_ready is not re-asserted in that same cycle, so accepts are at least two
// cycles apart.
//
// Optional feature macro: ALU_EXEC_MUL_EN
//   Defined   -> code 011 is an iterative shift-add unsigned multiply. It spends
//                WIDTH cycles in BUSY and returns the low WIDTH bits of a*b.
//   Undefined -> no BUSY state, counter or accumulator is built, and code 011
//                is reported as illegal.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   in_valid    request present
//   in_ready    unit idle and able to accept a request
//   alucontrol  operation code (010 add, 110 sub, 000 and, 001 or, 111 slt, 011 mul)
//   a, b        operands, WIDTH bits
//   out_valid   result, zero and illegal are valid
//   out_ready   consumer takes the result this cycle
//   result      registered operation result
//   zero        result == 0 on a legal operation
//   illegal     captured code was unsupported
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b111;
`ifdef ALU_EXEC_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam int         CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`endif

`ifdef ALU_EXEC_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t state;

    // Single-cycle operation. Returns {illegal, result}; an unsupported code
    // yields result 0 with the illegal bit set.
    function automatic logic [WIDTH:0] alu_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        logic        [WIDTH-1:0] r;
        logic                    bad;
        xs  = x;
        ys  = y;
        r   = '0;
        bad = 1'b0;
        case (op)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (xs < ys)};
            default: bad = 1'b1;
        endcase
        return {bad, r};
    endfunction

    logic [WIDTH:0]   op_res;
    logic [WIDTH-1:0] op_val;
    logic             op_bad;

    assign op_res = alu_op(alucontrol, a, b);
    assign op_bad = op_res[WIDTH];
    assign op_val = op_res[WIDTH-1:0];

`ifdef ALU_EXEC_MUL_EN
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;

    // One multiplier bit per cycle; only the low WIDTH bits are ever kept.
    assign acc_next = mplier[0] ? (acc + mcand) : acc;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
`endif
        end else begin
            case (state)
                // IDLE: in_ready is high here, so in_valid alone means accept.
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
                        if (alucontrol == OP_MUL) begin
                            state  <= BUSY;
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                        end else
`endif
                        begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= op_val;
                            illegal   <= op_bad;
                            zero      <= !op_bad && (op_val == '0);
                        end
                    end
                end
`ifdef ALU_EXEC_MUL_EN
                // BUSY: shift-add iteration, WIDTH cycles in total.
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= acc_next;
                        illegal   <= 1'b0;
                        zero      <= (acc_next == '0);
                    end
                end
`endif
                // DONE: hold outputs until the consumer takes them.
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
